// File: rtl/display_scan_ctrl_if.sv
// Debug-tap and board-pin bundle for display_scan_ctrl.
// The master drives the channel taps and controls; the slave drives the display pins.
interface display_scan_ctrl_if #(
  parameter int NUM_CH     = 4,
  parameter int CH_SEL_W   = 2,
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
);
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [CH_SEL_W-1:0]      ch_sel;
  logic                     blank_lz;
  logic                     freeze;
  logic [7:0]               LED;
  logic [NUM_DIGITS-1:0]    bcd_enable;
  logic [6:0]               bcd_signal;
  logic                     frame_done;

  modport master (
    output ch_data, ch_sel, blank_lz, freeze,
    input  LED, bcd_enable, bcd_signal, frame_done
  );

  modport slave (
    input  ch_data, ch_sel, blank_lz, freeze,
    output LED, bcd_enable, bcd_signal, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed hex display scanner: snapshots one debug channel per frame and
// time-multiplexes its nibbles across the seven-segment digits.
module display_scan_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CH_SEL_W    = 2,
  parameter int DATA_W      = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              sys_clk,
  input  logic              reset,
  display_scan_ctrl_if.slave bus
);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]      r_presc;
  logic [DIG_W-1:0]      r_digit_idx;
  logic [DATA_W-1:0]     r_snapshot;
  logic [7:0]            r_led;
  logic [NUM_DIGITS-1:0] r_bcd_enable;
  logic [6:0]            r_bcd_signal;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_wrap;
  logic [DATA_W-1:0]     w_channels [NUM_CH];
  logic [DATA_W-1:0]     w_sel_data;
  logic [3:0]            w_nibbles [NUM_DIGITS];
  logic [3:0]            w_cur_nib;
  logic [NUM_DIGITS-1:0] w_enable_n;
  logic                  w_upper_zero;
  logic                  w_blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_channels[gi] = bus.ch_data[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      assign w_nibbles[gi]  = r_snapshot[gi*4 +: 4];
      assign w_enable_n[gi] = (r_digit_idx != DIG_W'(gi));
    end
  endgenerate

  assign w_tick    = (r_presc == PRE_LAST);
  assign w_wrap    = w_tick && (r_digit_idx == DIG_LAST);
  assign w_cur_nib = w_nibbles[r_digit_idx];

  // Unmatched select codes fall through to channel 0.
  always_comb begin
    w_sel_data = w_channels[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (bus.ch_sel == CH_SEL_W'(k)) w_sel_data = w_channels[k];
    end
  end

  // True when the current digit and every more significant one are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((DIG_W'(j) >= r_digit_idx) && (w_nibbles[j] != 4'h0)) w_upper_zero = 1'b0;
    end
  end

  assign w_blank = bus.blank_lz && (r_digit_idx != '0) && w_upper_zero;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_presc      <= '0;
      r_digit_idx  <= '0;
      r_snapshot   <= '0;
      r_led        <= 8'h00;
      r_bcd_enable <= '1;
      r_bcd_signal <= 7'h7F;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_frame_done <= w_wrap;
      if (w_tick) r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
      if (w_wrap && !bus.freeze) r_snapshot <= w_sel_data;
      r_led <= r_snapshot[7:0];
      if (w_blank) begin
        r_bcd_enable <= '1;
        r_bcd_signal <= 7'h7F;
      end else begin
        r_bcd_enable <= w_enable_n;
        r_bcd_signal <= hex_to_seg(w_cur_nib);
      end
    end
  end

  assign bus.LED        = r_led;
  assign bus.bcd_enable = r_bcd_enable;
  assign bus.bcd_signal = r_bcd_signal;
  assign bus.frame_done = r_frame_done;
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment and LED display controller for the FPGA processor board.
- Selects one of NUM_CH debug channels (PC, register values, ALU result, ...) and snapshots it once per scan frame, so digits never tear mid-frame.
- Drives NUM_DIGITS time-multiplexed hex digits. Supports optional leading-zero blanking and a freeze mode.
- Sits between the processor debug taps and the board pins.

Parameters:
- NUM_CH, 4, number of input data channels (>=2).
- CH_SEL_W, 2, width of ch_sel; must equal clog2(NUM_CH).
- DATA_W, 16, width of each channel; must be >= 4*NUM_DIGITS and >= 8.
- NUM_DIGITS, 4, number of seven-segment digits scanned.
- REFRESH_DIV, 100000, sys_clk cycles per digit slot (>=2).

Ports:
- sys_clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ch_data  input  NUM_CH*DATA_W  flattened channels; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_sel  input  CH_SEL_W  channel select; values >= NUM_CH select channel 0.
- blank_lz  input  1  1 = blank leading-zero digits.
- freeze  input  1  1 = hold the current snapshot.
- LED  output  8  snapshot[7:0], active-high.
- bcd_enable  output  NUM_DIGITS  digit anodes, active-low, at most one low.
- bcd_signal  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, async): prescaler=0, digit_idx=0, snapshot=0, LED=8'h00, bcd_enable=all ones, bcd_signal=7'h7F, frame_done=0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick is asserted in the cycle where prescaler==REFRESH_DIV-1.
- Digit index: on tick, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
- Frame wrap (tick while digit_idx==NUM_DIGITS-1):
  - snapshot <= selected channel, unless freeze=1, in which case snapshot holds.
  - frame_done <= 1 for exactly one cycle. It pulses regardless of freeze.
- ch_sel and ch_data are sampled only at frame wrap. Changes mid-frame have no visible effect until the next wrap.
- Outputs are registered from digit_idx and snapshot (1-cycle latency):
  - bcd_enable = ~(1 << digit_idx).
  - bcd_signal = encoding of nibble snapshot[4*digit_idx +: 4].
  - LED = snapshot[7:0].
- First clock edge after reset release: bcd_enable=...1110, bcd_signal=7'b1000000 (digit "0").
- Hex encoding (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking:
  - Condition: blank_lz=1, digit_idx>0, and every nibble from digit_idx up to NUM_DIGITS-1 is zero.
  - Result: bcd_signal=7'h7F and bcd_enable=all ones for that slot.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - blank_lz is evaluated live, not snapshotted.
- Snapshot bits above 4*NUM_DIGITS-1 appear only on LED (when in [7:0]); otherwise they are ignored.
- freeze and a frame wrap in the same cycle: freeze wins, and frame_done still pulses.
- Reset asserted mid-frame: all state clears immediately (async). Scan restarts at digit 0 with snapshot 0.
- No combinational path from any input to any output.

Test Plan:
- Reset and initial frame (REFRESH_DIV=4, NUM_DIGITS=4, defaults otherwise): hold reset=0 for 3 cycles, then release.
  - During reset: bcd_enable=4'b1111, bcd_signal=7'h7F, LED=0.
  - After release: digit 0 shows "0"; digit_idx advances every 4 cycles.
  - frame_done pulses at cycle 16.
- Channel capture: ch_data ch2=16'h1A3F, ch_sel=2, run one frame, then a second frame.
  - Second frame scans digits 0..3 as F (0001110), 3 (0110000), A (0001000), 1 (1111001).
  - LED=8'h3F.
- Mid-frame select change: ch_sel changes 2->1 (ch1=16'h00B7) while digit_idx=1.
  - Remainder of the frame still shows 1A3F; the next frame shows 00B7.
- Leading-zero blanking: blank_lz=1 with ch1=16'h00B7.
  - Digits 2 and 3: bcd_enable=4'b1111, bcd_signal=7'h7F.
  - Digits 0/1 show 7/b.
  - With value 16'h0000, only digit 0 lights, showing "0".
- Freeze and out-of-range select:
  - freeze=1, then change ch_data: display holds its value across 3 frames while frame_done still pulses each frame.
  - Release freeze with ch_sel=3, NUM_CH=3, CH_SEL_W=2: the next frame shows channel 0.
- Async reset mid-frame: assert reset=0 at digit_idx=2, between clock edges.
  - Outputs go to their reset values immediately (without waiting for a clock edge); snapshot=0 after release.
